// File: rtl/sram_fifo_ctl_if.sv
// rtl/sram_fifo_ctl_if.sv - stream, status and SRAM controller signals of sram_fifo_ctl
interface sram_fifo_ctl_if #(
  parameter int ADDR_W = 23
);
  logic [15:0]       IN_DATA;
  logic              IN_VALID;
  logic              IN_READY;
  logic [15:0]       OUT_DATA;
  logic              OUT_VALID;
  logic              OUT_READY;
  logic [ADDR_W:0]   SIZE;
  logic              FULL;
  logic              EMPTY;
  logic [ADDR_W-1:0] SRAM_ADDR_WR;
  logic [ADDR_W-1:0] SRAM_ADDR_RD;
  logic [15:0]       SRAM_DATA_IN;
  logic              SRAM_WE;
  logic              SRAM_RD;
  logic [15:0]       SRAM_DATA_OUT;
  logic              SRAM_DATA_OUT_VALID;

  modport master (
    input  IN_DATA, IN_VALID, OUT_READY, SRAM_DATA_OUT, SRAM_DATA_OUT_VALID,
    output IN_READY, OUT_DATA, OUT_VALID, SIZE, FULL, EMPTY,
           SRAM_ADDR_WR, SRAM_ADDR_RD, SRAM_DATA_IN, SRAM_WE, SRAM_RD
  );

  modport slave (
    output IN_DATA, IN_VALID, OUT_READY, SRAM_DATA_OUT, SRAM_DATA_OUT_VALID,
    input  IN_READY, OUT_DATA, OUT_VALID, SIZE, FULL, EMPTY,
           SRAM_ADDR_WR, SRAM_ADDR_RD, SRAM_DATA_IN, SRAM_WE, SRAM_RD
  );
endinterface

// File: rtl/sram_fifo_ctl.sv
// rtl/sram_fifo_ctl.sv - streams through a ZBT SRAM as one large FIFO with a credit-limited FWFT output buffer
module sram_fifo_ctl #(
  parameter int ADDR_W    = 23,
  parameter int WR_LAT    = 3,
  parameter int RD_LAT    = 2,
  parameter int OUT_DEPTH = 8
) (
  input logic            CLK,
  input logic            RESET,
  sram_fifo_ctl_if.master bus
);
  localparam int CW = $clog2(OUT_DEPTH + 1);
  localparam int BW = $clog2(OUT_DEPTH);
  localparam int IW = $clog2(RD_LAT + 1);
  localparam int PL = WR_LAT - 1;
  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(1) << ADDR_W;

  logic [ADDR_W:0] wr_ptr, rd_ptr, size, avail;
  logic [PL-1:0]   commit_sr;
  logic [CW-1:0]   inflight, buf_count;
  logic [BW-1:0]   buf_wp, buf_rp;
  logic [15:0]     buf_mem [OUT_DEPTH];
  logic [IW-1:0]   ign_cnt;
  logic            full, in_ready, accept, commit, rd_issue, ret, pop, out_valid;

  assign size      = wr_ptr - rd_ptr;
  assign full      = (size == DEPTH);
  assign in_ready  = ~full & ~RESET;
  assign accept    = bus.IN_VALID & in_ready;
  // The shift register is one stage shorter than WR_LAT because avail is itself a
  // register: the word becomes readable exactly WR_LAT cycles after its accept.
  assign commit    = commit_sr[PL-1];
  assign rd_issue  = ~RESET & (avail != '0) &
                     (((CW+1)'(inflight) + (CW+1)'(buf_count)) < (CW+1)'(OUT_DEPTH));
  assign ret       = bus.SRAM_DATA_OUT_VALID & (ign_cnt == '0);
  assign out_valid = (buf_count != '0);
  assign pop       = out_valid & bus.OUT_READY;

  assign bus.IN_READY     = in_ready;
  assign bus.SRAM_WE      = accept;
  assign bus.SRAM_ADDR_WR = wr_ptr[ADDR_W-1:0];
  assign bus.SRAM_DATA_IN = bus.IN_DATA;
  assign bus.SRAM_RD      = rd_issue;
  assign bus.SRAM_ADDR_RD = rd_ptr[ADDR_W-1:0];
  assign bus.OUT_VALID    = out_valid;
  assign bus.OUT_DATA     = buf_mem[buf_rp];
  assign bus.SIZE         = size;
  assign bus.FULL         = full;
  assign bus.EMPTY        = (size == '0) & (buf_count == '0);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      avail     <= '0;
      commit_sr <= '0;
      inflight  <= '0;
      buf_count <= '0;
      buf_wp    <= '0;
      buf_rp    <= '0;
      // Reads still in the controller pipeline come back after reset and must be dropped.
      ign_cnt   <= IW'(RD_LAT);
    end else begin
      if (accept)
        wr_ptr <= wr_ptr + 1'b1;
      if (rd_issue)
        rd_ptr <= rd_ptr + 1'b1;
      commit_sr <= (commit_sr << 1) | PL'(accept);
      avail     <= avail + (ADDR_W+1)'(commit) - (ADDR_W+1)'(rd_issue);
      inflight  <= inflight + CW'(rd_issue) - CW'(ret);
      buf_count <= buf_count + CW'(ret) - CW'(pop);
      if (ret)
        buf_wp <= buf_wp + 1'b1;
      if (pop)
        buf_rp <= buf_rp + 1'b1;
      if (ign_cnt != '0)
        ign_cnt <= ign_cnt - 1'b1;
      assert (!(ret && !pop && buf_count == CW'(OUT_DEPTH)));
    end
  end

  always_ff @(posedge CLK) begin
    if (ret && !RESET)
      buf_mem[buf_wp] <= bus.SRAM_DATA_OUT;
  end
endmodule
